// File: rtl/occ_line_responder_if.sv
// rtl/occ_line_responder_if.sv - request, memory and result signal bundle for the occurrence line responder
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 8
`endif

interface occ_line_responder_if #(
   parameter int ADDR_W = 42,
   parameter int DATA_W = 512,
   parameter int RN_W   = `READ_NUM_WIDTH
);
   logic              request_valid;
   logic [ADDR_W-1:0] addr_k;
   logic [ADDR_W-1:0] addr_l;
   logic [RN_W-1:0]   read_num;
   logic              stall;
   logic              mem_rd_valid;
   logic              mem_rd_ready;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [RN_W-1:0]   rsp_read_num;
   logic [DATA_W-1:0] rsp_line_k;
   logic [DATA_W-1:0] rsp_line_l;

   modport slave (
      input  request_valid, addr_k, addr_l, read_num,
      input  mem_rd_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
      output stall, mem_rd_valid, mem_rd_addr,
      output rsp_valid, rsp_read_num, rsp_line_k, rsp_line_l
   );

   modport master (
      output request_valid, addr_k, addr_l, read_num,
      output mem_rd_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
      input  stall, mem_rd_valid, mem_rd_addr,
      input  rsp_valid, rsp_read_num, rsp_line_k, rsp_line_l
   );
endinterface

// File: rtl/occ_line_responder.sv
// rtl/occ_line_responder.sv - fetches and pairs k/l cache lines for queued occurrence requests
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 8
`endif

module occ_line_responder #(
   parameter int ADDR_W = 42,
   parameter int DATA_W = 512,
   parameter int RN_W   = `READ_NUM_WIDTH,
   parameter int DEPTH  = 4
) (
   input logic clk,
   input logic rst,
   occ_line_responder_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {IDLE, ISSUE_K, ISSUE_L, WAIT, OUT} state_t;

   logic [RN_W-1:0]   fifo_rn_q  [DEPTH];
   logic [ADDR_W-1:0] fifo_k_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_l_q   [DEPTH];
   logic              fifo_dup_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          stall_q, stall_d;
   logic          push, pop;

   state_t            state_q, state_d;
   logic [RN_W-1:0]   rn_q, rn_d;
   logic [ADDR_W-1:0] k_q, k_d, l_q, l_d;
   logic              dup_q, dup_d;
   logic [DATA_W-1:0] line_k_q, line_k_d, line_l_q, line_l_d;
   logic [1:0]        got_q, got_d;
   logic [1:0]        outst_q, outst_d;
   logic              mem_rd_valid_q, mem_rd_valid_d;
   logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              hs, take, complete;

   // FIFO bookkeeping; stall is registered from the next count so it tracks count == DEPTH exactly
   always_comb begin
      push     = bus.request_valid && !stall_q;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      stall_d  = (count_d == CW'(DEPTH));
   end

   // FIFO storage; emptiness is carried by count, so entries need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rn_q[wr_ptr_q]  <= bus.read_num;
         fifo_k_q[wr_ptr_q]   <= bus.addr_k;
         fifo_l_q[wr_ptr_q]   <= bus.addr_l;
         fifo_dup_q[wr_ptr_q] <= (bus.addr_k == bus.addr_l);
      end
   end

   // Request sequencing: issue k (and l unless duplicate), collect lines in order, hold result until taken
   always_comb begin
      state_d  = state_q;
      rn_d     = rn_q;
      k_d      = k_q;
      l_d      = l_q;
      dup_d    = dup_q;
      line_k_d = line_k_q;
      line_l_d = line_l_q;
      pop      = 1'b0;

      hs   = mem_rd_valid_q && bus.mem_rd_ready;
      // Responses only count while this request has commands in flight; stale or stray ones are dropped
      take = bus.mem_rsp_valid && (state_q inside {ISSUE_K, ISSUE_L, WAIT}) &&
             ((outst_q != 2'd0) || hs);
      outst_d = outst_q + {1'b0, hs} - {1'b0, take};
      got_d   = got_q + {1'b0, take};
      complete = (got_d == (dup_q ? 2'd1 : 2'd2));

      if (take) begin
         if (got_q == 2'd0) begin
            line_k_d = bus.mem_rsp_data;
            if (dup_q) line_l_d = bus.mem_rsp_data;
         end else begin
            line_l_d = bus.mem_rsp_data;
         end
      end

      case (state_q)
         IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         ISSUE_K: begin
            if (hs) begin
               if (dup_q) state_d = complete ? OUT : WAIT;
               else       state_d = ISSUE_L;
            end
         end
         ISSUE_L: begin
            if (hs) state_d = complete ? OUT : WAIT;
         end
         WAIT: begin
            if (complete) state_d = OUT;
         end
         OUT: begin
            if (bus.rsp_ready) begin
               if (count_q != '0) pop = 1'b1;
               else               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         state_d = ISSUE_K;
         rn_d    = fifo_rn_q[rd_ptr_q];
         k_d     = fifo_k_q[rd_ptr_q];
         l_d     = fifo_l_q[rd_ptr_q];
         dup_d   = fifo_dup_q[rd_ptr_q];
         got_d   = 2'd0;
      end

      mem_rd_valid_d = (state_d == ISSUE_K) || (state_d == ISSUE_L);
      if (state_d == ISSUE_K)      mem_rd_addr_d = k_d;
      else if (state_d == ISSUE_L) mem_rd_addr_d = l_d;
      else                         mem_rd_addr_d = mem_rd_addr_q;
      rsp_valid_d = (state_d == OUT);
   end

   // State and output registers; reset discards queued and in-flight work
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         stall_q        <= 1'b0;
         state_q        <= IDLE;
         rn_q           <= '0;
         k_q            <= '0;
         l_q            <= '0;
         dup_q          <= 1'b0;
         line_k_q       <= '0;
         line_l_q       <= '0;
         got_q          <= '0;
         outst_q        <= '0;
         mem_rd_valid_q <= 1'b0;
         mem_rd_addr_q  <= '0;
         rsp_valid_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         stall_q        <= stall_d;
         state_q        <= state_d;
         rn_q           <= rn_d;
         k_q            <= k_d;
         l_q            <= l_d;
         dup_q          <= dup_d;
         line_k_q       <= line_k_d;
         line_l_q       <= line_l_d;
         got_q          <= got_d;
         outst_q        <= outst_d;
         mem_rd_valid_q <= mem_rd_valid_d;
         mem_rd_addr_q  <= mem_rd_addr_d;
         rsp_valid_q    <= rsp_valid_d;
      end
   end

   assign bus.stall        = stall_q;
   assign bus.mem_rd_valid = mem_rd_valid_q;
   assign bus.mem_rd_addr  = mem_rd_addr_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_read_num = rn_q;
   assign bus.rsp_line_k   = line_k_q;
   assign bus.rsp_line_l   = line_l_q;
endmodule

// File: tb/tb_occ_line_responder.sv
// tb/tb_occ_line_responder.sv - randomized self-checking bench for occ_line_responder
module tb_occ_line_responder;
   localparam int ADDR_W = 42;
   localparam int DATA_W = 512;
   localparam int RN_W   = 8;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   occ_line_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RN_W(RN_W)) bus ();

   occ_line_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RN_W(RN_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [ADDR_W-1:0] a;
      int                due;
   } pend_t;

   typedef struct {
      logic [RN_W-1:0]   rn;
      logic [ADDR_W-1:0] k;
      logic [ADDR_W-1:0] l;
   } exp_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mem_lat = 1;
   int rdy_mode = 0;
   int n_ret = 0;
   int first_valid_cyc = -1;
   pend_t             pend[$];
   logic [ADDR_W-1:0] hs_addrs[$];
   exp_t              expq[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return {8{64'(a)}};
   endfunction

   function automatic logic [ADDR_W-1:0] rnd_addr();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[ADDR_W-1:0];
   endfunction

   // Memory model: in-order responses a fixed number of cycles after each accepted command
   initial begin
      bit                held;
      bit                held_rst;
      logic [ADDR_W-1:0] held_addr;
      held = 0;
      held_rst = 0;
      held_addr = '0;
      bus.mem_rd_ready  = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_rd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = line_of(pend[0].a);
            void'(pend.pop_front());
         end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
         end
         @(negedge clk);
         if (held && !held_rst) begin
            checks++;
            if (bus.mem_rd_valid !== 1'b1 || bus.mem_rd_addr !== held_addr) begin
               failures++;
               $display("FAIL cmd_stable valid=%0b addr=%h required valid=1 addr=%h",
                        bus.mem_rd_valid, bus.mem_rd_addr, held_addr);
            end
         end
         held      = (bus.mem_rd_valid === 1'b1) && !bus.mem_rd_ready;
         held_addr = bus.mem_rd_addr;
         held_rst  = rst;
         if (bus.mem_rd_valid === 1'b1 && bus.mem_rd_ready && !rst) begin
            hs_addrs.push_back(bus.mem_rd_addr);
            pend.push_back('{bus.mem_rd_addr, cyc + mem_lat});
         end
      end
   end

   // Result scoreboard: every taken result must be the oldest accepted request with its own lines
   initial begin
      bit                pv, pr, prst;
      logic [RN_W-1:0]   h_rn;
      logic [DATA_W-1:0] h_k, h_l;
      exp_t              e;
      pv = 0; pr = 0; prst = 0; h_rn = '0; h_k = '0; h_l = '0;
      forever begin
         @(negedge clk);
         if (pv && !pr && !prst) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_read_num !== h_rn ||
                bus.rsp_line_k !== h_k || bus.rsp_line_l !== h_l) begin
               failures++;
               $display("FAIL rsp_stable valid=%0b rn=%0d required valid=1 rn=%0d",
                        bus.rsp_valid, bus.rsp_read_num, h_rn);
            end
         end
         if (!rst && bus.rsp_valid === 1'b1) begin
            if (!pv) first_valid_cyc = cyc;
            if (bus.rsp_ready) begin
               checks++;
               n_ret++;
               if (expq.size() == 0) begin
                  failures++;
                  $display("FAIL rsp_unexpected rn=%0d required none", bus.rsp_read_num);
               end else begin
                  e = expq.pop_front();
                  if (bus.rsp_read_num !== e.rn || bus.rsp_line_k !== line_of(e.k) ||
                      bus.rsp_line_l !== line_of(e.l)) begin
                     failures++;
                     $display("FAIL rsp_match rn=%0d k=%h l=%h required rn=%0d k=%h l=%h",
                              bus.rsp_read_num, bus.rsp_line_k[63:0], bus.rsp_line_l[63:0],
                              e.rn, 64'(e.k), 64'(e.l));
                  end
               end
            end
         end
         pv   = (bus.rsp_valid === 1'b1);
         pr   = bus.rsp_ready;
         prst = rst;
         h_rn = bus.rsp_read_num;
         h_k  = bus.rsp_line_k;
         h_l  = bus.rsp_line_l;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic [RN_W-1:0] rn, input logic [ADDR_W-1:0] k,
                       input logic [ADDR_W-1:0] l, output int acc);
      int n;
      n = 0;
      bus.request_valid = 1'b1;
      bus.read_num      = rn;
      bus.addr_k        = k;
      bus.addr_l        = l;
      while (bus.stall === 1'b1 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL send_timeout rn=%0d stall=%0b required stall=0", rn, bus.stall);
         acc = -1;
      end else begin
         acc = cyc;
         expq.push_back('{rn, k, l});
      end
      @(posedge clk); #1;
      bus.request_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound, output bit ok);
      int n;
      n = 0;
      while (expq.size() != 0 && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (expq.size() == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++;
      if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b required=0", bus.stall); end
      checks++;
      if (bus.mem_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_valid got=%0b required=0", bus.mem_rd_valid); end
      checks++;
      if (bus.mem_rd_addr !== '0) begin failures++; $display("FAIL reset_mem_rd_addr got=%h required=0", bus.mem_rd_addr); end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b required=0", bus.rsp_valid); end
      checks++;
      if (bus.rsp_read_num !== '0) begin failures++; $display("FAIL reset_rsp_read_num got=%0d required=0", bus.rsp_read_num); end
      checks++;
      if (bus.rsp_line_k !== '0 || bus.rsp_line_l !== '0) begin
         failures++;
         $display("FAIL reset_rsp_lines got k=%h l=%h required 0", bus.rsp_line_k[63:0], bus.rsp_line_l[63:0]);
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_single();
      int acc;
      bit ok;
      rdy_mode = 0; mem_lat = 1; bus.rsp_ready = 1'b1;
      hs_addrs.delete();
      first_valid_cyc = -1;
      send(8'd3, 42'h10, 42'h20, acc);
      wait_drain(100, ok);
      tick(2);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_drain pending=%0d required=0", expq.size()); end
      checks++;
      if (first_valid_cyc - acc != 5) begin
         failures++;
         $display("FAIL single_latency got=%0d required=5", first_valid_cyc - acc);
      end
      checks++;
      if (hs_addrs.size() != 2) begin
         failures++;
         $display("FAIL single_cmd_count got=%0d required=2", hs_addrs.size());
      end else begin
         checks++;
         if (hs_addrs[0] !== 42'h10 || hs_addrs[1] !== 42'h20) begin
            failures++;
            $display("FAIL single_cmd_order got=%h,%h required=10,20", hs_addrs[0], hs_addrs[1]);
         end
      end
   endtask

   task automatic test_dup();
      int acc;
      bit ok;
      hs_addrs.delete();
      first_valid_cyc = -1;
      send(8'd7, 42'h40, 42'h40, acc);
      wait_drain(100, ok);
      tick(2);
      checks++;
      if (!ok) begin failures++; $display("FAIL dup_drain pending=%0d required=0", expq.size()); end
      checks++;
      if (first_valid_cyc - acc != 4) begin
         failures++;
         $display("FAIL dup_latency got=%0d required=4", first_valid_cyc - acc);
      end
      checks++;
      if (hs_addrs.size() != 1) begin
         failures++;
         $display("FAIL dup_cmd_count got=%0d required=1", hs_addrs.size());
      end
   endtask

   task automatic test_back_pressure();
      int acc;
      int base;
      bit ok;
      logic [ADDR_W-1:0] k, l;
      base = n_ret;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         k = rnd_addr();
         l = ($urandom_range(0, 3) == 0) ? k : rnd_addr();
         send(RN_W'(i), k, l, acc);
         if (i == 3) begin
            checks++;
            if (bus.stall !== 1'b0) begin failures++; $display("FAIL bp_stall_early got=%0b required=0", bus.stall); end
         end
      end
      checks++;
      if (bus.stall !== 1'b1) begin failures++; $display("FAIL bp_stall_full got=%0b required=1", bus.stall); end
      fork
         begin
            k = rnd_addr();
            send(8'd5, k, rnd_addr(), acc);
         end
         begin
            tick(12);
            checks++;
            if (bus.stall !== 1'b1) begin failures++; $display("FAIL bp_stall_hold got=%0b required=1", bus.stall); end
            bus.rsp_ready = 1'b1;
         end
      join
      wait_drain(400, ok);
      checks++;
      if (!ok || n_ret - base != 6) begin
         failures++;
         $display("FAIL bp_results got=%0d required=6", n_ret - base);
      end
   endtask

   task automatic test_throttle();
      int acc;
      int base;
      bit ok;
      logic [ADDR_W-1:0] k, l;
      base = n_ret;
      rdy_mode = 1; mem_lat = 7; bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         k = rnd_addr();
         l = ($urandom_range(0, 2) == 0) ? k : rnd_addr();
         send(RN_W'(8'h30 + i), k, l, acc);
      end
      wait_drain(2000, ok);
      checks++;
      if (!ok || n_ret - base != 8) begin
         failures++;
         $display("FAIL throttle_results got=%0d required=8", n_ret - base);
      end
      rdy_mode = 0; mem_lat = 1;
      tick(4);
   endtask

   task automatic test_reset_mid_wait();
      int acc;
      int n;
      bit ok;
      rdy_mode = 0; mem_lat = 7; bus.rsp_ready = 1'b1;
      hs_addrs.delete();
      send(8'd9, 42'h111, 42'h222, acc);
      n = 0;
      while (hs_addrs.size() < 2 && n < 50) begin
         tick(1);
         n++;
      end
      checks++;
      if (hs_addrs.size() != 2) begin failures++; $display("FAIL rmw_cmds got=%0d required=2", hs_addrs.size()); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expq.delete();
      checks++;
      if (bus.mem_rd_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.stall !== 1'b0 ||
          bus.mem_rd_addr !== '0 || bus.rsp_read_num !== '0 ||
          bus.rsp_line_k !== '0 || bus.rsp_line_l !== '0) begin
         failures++;
         $display("FAIL rmw_reset_outputs rd_valid=%0b rsp_valid=%0b rn=%0d required all 0",
                  bus.mem_rd_valid, bus.rsp_valid, bus.rsp_read_num);
      end
      n = 0;
      while (pend.size() != 0 && n < 50) begin
         tick(1);
         n++;
      end
      tick(3);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_line_k !== '0 || bus.rsp_line_l !== '0) begin
         failures++;
         $display("FAIL rmw_stale_dropped rsp_valid=%0b k=%h required 0", bus.rsp_valid, bus.rsp_line_k[63:0]);
      end
      mem_lat = 1;
      send(8'd10, 42'h333, 42'h444, acc);
      wait_drain(100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmw_after_reset pending=%0d required=0", expq.size()); end
   endtask

   task automatic test_wrap();
      int acc;
      int base;
      bit ok;
      logic [ADDR_W-1:0] k, l;
      base = n_ret;
      rdy_mode = 0; mem_lat = 1; bus.rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         k = rnd_addr();
         l = ($urandom_range(0, 4) == 0) ? k : rnd_addr();
         send(RN_W'(i), k, l, acc);
      end
      wait_drain(1000, ok);
      checks++;
      if (!ok || n_ret - base != 20) begin
         failures++;
         $display("FAIL wrap_results got=%0d required=20", n_ret - base);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d required completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.request_valid = 1'b0;
      bus.read_num      = '0;
      bus.addr_k        = '0;
      bus.addr_l        = '0;
      bus.rsp_ready     = 1'b1;
      tick(1);
      test_reset();
      test_single();
      test_dup();
      test_back_pressure();
      test_throttle();
      test_reset_mid_wait();
      test_wrap();
      tick(5);
      checks++;
      if (expq.size() != 0) begin failures++; $display("FAIL final_pending got=%0d required=0", expq.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
